// File: rtl/rast_tri_feeder.sv
// rast_tri_feeder: FIFO-buffered triangle source for rast's R10 input port.
// Optional RAST_FEED_DEGEN_DROP_EN drops zero-area triangles at push.
module rast_tri_feeder #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int DEPTH  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] in_tri,
  input  logic [COLORS-1:0][SIGFIG-1:0] in_color,
  input  logic in_valid,
  output logic in_ready,
  input  logic halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
  output logic [COLORS-1:0][SIGFIG-1:0] color_R10U,
  output logic validTri_R10H,
  output logic [$clog2(DEPTH+2)-1:0] occupancy,
  output logic [15:0] issued_count
`ifdef RAST_FEED_DEGEN_DROP_EN
  ,
  output logic [15:0] dropped_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(DEPTH+2);

  typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0] col_t;

  if (RADIX >= SIGFIG || DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0)
    begin : g_bad_param
      $error("rast_tri_feeder: bad parameters");
    end

  tri_t mem_tri [DEPTH];
  col_t mem_col [DEPTH];

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] fifo_count;

  logic push, keep, load, fire;
  logic empty, bypass, wr, pop;

  assign in_ready = rst && (fifo_count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign fire     = validTri_R10H && halt_RnnnnL;
  assign load     = !validTri_R10H || halt_RnnnnL;
  assign empty    = (fifo_count == '0);

`ifdef RAST_FEED_DEGEN_DROP_EN
  localparam int A2W = 2*SIGFIG+2;
  logic signed [SIGFIG:0] dx1, dy1, dx2, dy2;
  logic signed [A2W-1:0] area2;
  logic degen;

  assign dx1 = (SIGFIG+1)'($signed(in_tri[1][0]))
             - (SIGFIG+1)'($signed(in_tri[0][0]));
  assign dy1 = (SIGFIG+1)'($signed(in_tri[1][1]))
             - (SIGFIG+1)'($signed(in_tri[0][1]));
  assign dx2 = (SIGFIG+1)'($signed(in_tri[2][0]))
             - (SIGFIG+1)'($signed(in_tri[0][0]));
  assign dy2 = (SIGFIG+1)'($signed(in_tri[2][1]))
             - (SIGFIG+1)'($signed(in_tri[0][1]));
  assign area2 = A2W'(dx1) * A2W'(dy2) - A2W'(dx2) * A2W'(dy1);
  assign degen = (area2 == '0);
  assign keep  = push && !degen;

  // count handshakes that were swallowed as zero-area
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      dropped_count <= '0;
    else if (push && degen)
      dropped_count <= dropped_count + 16'd1;
  end
`else
  assign keep = push;
`endif

  assign bypass = load && empty && keep;
  assign wr     = keep && !bypass;
  assign pop    = load && !empty;

  assign occupancy = OW'(fifo_count) + OW'(validTri_R10H);

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_tri[wptr] <= in_tri;
      mem_col[wptr] <= in_color;
    end
  end

  // FIFO pointers and count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      fifo_count <= fifo_count + CW'(wr) - CW'(pop);
    end
  end

  // output register: FIFO head first, else same-cycle bypass
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tri_R10S      <= '0;
      color_R10U    <= '0;
      validTri_R10H <= 1'b0;
      issued_count  <= '0;
    end else begin
      if (fire)
        issued_count <= issued_count + 16'd1;
      if (load) begin
        if (!empty) begin
          tri_R10S      <= mem_tri[rptr];
          color_R10U    <= mem_col[rptr];
          validTri_R10H <= 1'b1;
        end else if (keep) begin
          tri_R10S      <= in_tri;
          color_R10U    <= in_color;
          validTri_R10H <= 1'b1;
        end else begin
          validTri_R10H <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rast_tri_feeder.sv
// tb_rast_tri_feeder: directed and scoreboarded bench for rast_tri_feeder.
// Define RAST_FEED_DEGEN_DROP_EN to exercise the zero-area drop path.
module tb_rast_tri_feeder;

  typedef logic signed [2:0][2:0][23:0] tri_t;
  typedef logic [2:0][23:0] col_t;
  typedef struct {
    tri_t t;
    col_t c;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  tri_t in_tri = '0;
  col_t in_color = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic halt = 1'b1;
  tri_t tri_R10S;
  col_t color_R10U;
  logic validTri_R10H;
  logic [2:0] occupancy;
  logic [15:0] issued_count;
`ifdef RAST_FEED_DEGEN_DROP_EN
  logic [15:0] dropped_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int fires = 0;
  ent_t q[$];
  bit done = 0;

  always #5 clk = ~clk;

  rast_tri_feeder dut (
    .clk(clk),
    .rst(rst),
    .in_tri(in_tri),
    .in_color(in_color),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .halt_RnnnnL(halt),
    .tri_R10S(tri_R10S),
    .color_R10U(color_R10U),
    .validTri_R10H(validTri_R10H),
    .occupancy(occupancy),
    .issued_count(issued_count)
`ifdef RAST_FEED_DEGEN_DROP_EN
    ,
    .dropped_count(dropped_count)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tri_t mk_tri(input int i);
    tri_t t;
    t = '0;
    t[0][0] = 24'(i);
    t[0][1] = 24'(2*i);
    t[0][2] = 24'd3;
    t[1][0] = 24'(4096+i);
    t[1][1] = 24'd5;
    t[1][2] = 24'd7;
    t[2][0] = 24'd11;
    t[2][1] = 24'(4096+2*i);
    t[2][2] = 24'd13;
    return t;
  endfunction

  function automatic col_t mk_col(input int i);
    col_t c;
    c[0] = 24'hFF;
    c[1] = 24'(3*i);
    c[2] = 24'(i);
    return c;
  endfunction

  function automatic bit is_degen(input tri_t t);
    longint x0, y0, x1, y1, x2, y2;
    x0 = longint'($signed(t[0][0]));
    y0 = longint'($signed(t[0][1]));
    x1 = longint'($signed(t[1][0]));
    y1 = longint'($signed(t[1][1]));
    x2 = longint'($signed(t[2][0]));
    y2 = longint'($signed(t[2][1]));
    return ((x1-x0)*(y2-y0) - (x2-x0)*(y1-y0)) == 0;
  endfunction

  // called at posedge+1; returns at posedge+1 of the accepting edge
  task automatic send(input tri_t t, input col_t c);
    int n;
    n = 0;
    in_tri = t;
    in_color = c;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // scoreboard and hold monitor, sampled mid-cycle
  initial begin
    bit prev_hold;
    tri_t prev_t;
    col_t prev_c;
    bit keep;
    ent_t e;
    prev_hold = 0;
    prev_t = '0;
    prev_c = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_hold = 0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", validTri_R10H, 1);
          chk("hold_tri", tri_R10S, prev_t);
          chk("hold_col", color_R10U, prev_c);
        end
        if (validTri_R10H && halt) begin
          fires++;
          if (q.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            e = q.pop_front();
            chk("sb_tri", tri_R10S, e.t);
            chk("sb_col", color_R10U, e.c);
          end
        end
        prev_hold = validTri_R10H && !halt;
        prev_t = tri_R10S;
        prev_c = color_R10U;
        keep = 1;
`ifdef RAST_FEED_DEGEN_DROP_EN
        keep = !is_degen(in_tri);
`endif
        if (in_valid && in_ready && keep) begin
          e.t = in_tri;
          e.c = in_color;
          q.push_back(e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tri_t t1;
    col_t c1;
    int f0, n;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", validTri_R10H, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_issued", issued_count, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_tri", tri_R10S, 0);
`ifdef RAST_FEED_DEGEN_DROP_EN
    chk("rst_dropped", dropped_count, 0);
`endif
    rst = 1'b1;
    #1;
    chk("ready_after_rst", in_ready, 1);

    // single push, bypass latency one cycle
    t1 = '0;
    t1[1][0] = 24'd4096;
    t1[2][1] = 24'd4096;
    c1 = '0;
    c1[2] = 24'hFF;
    halt = 1'b1;
    @(posedge clk);
    #1;
    send(t1, c1);
    chk("single_valid", validTri_R10H, 1);
    chk("single_tri", tri_R10S, t1);
    chk("single_col", color_R10U, c1);
    chk("single_occ", occupancy, 1);
    @(posedge clk);
    #1;
    chk("single_issued", issued_count, 1);
    chk("single_occ0", occupancy, 0);
    chk("single_valid0", validTri_R10H, 0);

    // halt hold: fill output register plus FIFO
    halt = 1'b0;
    for (int i = 0; i < 5; i++) send(mk_tri(i), mk_col(i));
    chk("halt_occ5", occupancy, 5);
    chk("halt_ready0", in_ready, 0);
    chk("halt_tri0", tri_R10S, mk_tri(0));
    in_tri = mk_tri(5);
    in_color = mk_col(5);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("halt_stall_ready", in_ready, 0);
    chk("halt_stall_occ", occupancy, 5);
    chk("halt_stall_tri", tri_R10S, mk_tri(0));
    halt = 1'b1;
    fork
      send(mk_tri(5), mk_col(5));
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          chk("no_bubble", validTri_R10H, 1);
        end
      end
    join
    @(posedge clk);
    #1;
    chk("halt_issued", issued_count, 7);
    chk("halt_occ_end", occupancy, 0);

    // streaming with random halt
    f0 = fires;
    done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(mk_tri(100+i), mk_col(100+i));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          halt = ($urandom_range(0, 9) >= 3);
        end
      end
    join
    halt = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    chk("stream_fires", fires - f0, 200);
    chk("stream_issued", issued_count, 207);
    chk("stream_occ", occupancy, 0);

    // continuous push with halt high: one per cycle via bypass
    for (int i = 0; i < 20; i++) begin
      send(mk_tri(20+i), mk_col(20+i));
      chk("bypass_occ", occupancy, 1);
    end
    @(posedge clk);
    #1;
    chk("bypass_issued", issued_count, 227);

    // async reset with triangles buffered
    halt = 1'b0;
    for (int i = 0; i < 4; i++) send(mk_tri(40+i), mk_col(40+i));
    chk("prerst_occ", occupancy, 4);
    #3;
    rst = 1'b0;
    q.delete();
    fires = 0;
    #1;
    chk("arst_valid", validTri_R10H, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_ready", in_ready, 0);
    chk("arst_issued", issued_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    halt = 1'b1;
    send(mk_tri(50), mk_col(50));
    chk("post_valid", validTri_R10H, 1);
    chk("post_tri", tri_R10S, mk_tri(50));
    chk("post_occ", occupancy, 1);
    @(posedge clk);
    #1;
    chk("post_alone", validTri_R10H, 0);
    chk("post_occ0", occupancy, 0);
    chk("post_issued", issued_count, 1);

`ifdef RAST_FEED_DEGEN_DROP_EN
    // zero-area triangle is accepted then dropped
    t1 = '0;
    t1[1][0] = 24'd1024;
    t1[1][1] = 24'd1024;
    t1[2][0] = 24'd2048;
    t1[2][1] = 24'd2048;
    chk("degen_model", is_degen(t1), 1);
    send(t1, mk_col(70));
    chk("degen_valid", validTri_R10H, 0);
    chk("degen_occ", occupancy, 0);
    chk("degen_dropped", dropped_count, 1);
    send(mk_tri(60), mk_col(60));
    chk("degen_next_tri", tri_R10S, mk_tri(60));
    @(posedge clk);
    #1;
    chk("degen_issued", issued_count, 2);
    chk("degen_dropped2", dropped_count, 1);
`endif

    chk("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rast_tri_feeder.md
Name: rast_tri_feeder

Overview:
- Triangle source for the rast pipeline: accepts triangles and colors from an upstream producer over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drives rast's R10 inputs (tri_R10S, color_R10U, validTri_R10H) and obeys rast's halt_RnnnnL back-pressure.
- Sits between the scene/vertex front end (or the bench) and rast's input port.

Parameters:
SIGFIG, 24, bits per coordinate/color word
RADIX, 10, fraction bits (carried only, no arithmetic on it)
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex
COLORS, 3, color channels
DEPTH, 4, FIFO entries (power of 2, >=2), excluding the output register

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_tri  in  signed [SIGFIG-1:0] [VERTS-1:0][AXIS-1:0]  upstream triangle
in_color  in  [SIGFIG-1:0] [COLORS-1:0]  upstream color
in_valid  in  1  upstream triangle valid
in_ready  out  1  feeder can accept
halt_RnnnnL  in  1  from rast; 0 = rast stalled
tri_R10S  out  signed [SIGFIG-1:0] [VERTS-1:0][AXIS-1:0]  to rast
color_R10U  out  [SIGFIG-1:0] [COLORS-1:0]  to rast
validTri_R10H  out  1  to rast
occupancy  out  $clog2(DEPTH+2)  FIFO entries plus output register
issued_count  out  16  triangles accepted by rast, wraps at 2^16

Behaviour:
- Reset (rst=0, asynchronous):
  - validTri_R10H=0; tri_R10S, color_R10U = 0.
  - FIFO pointers, occupancy and issued_count = 0.
  - in_ready=0 while rst=0.
- Upstream push: push = in_valid && in_ready. in_ready = (fifo_count < DEPTH), combinational from registered count. Full FIFO gives in_ready=0, and the upstream must hold its data.
- Downstream consume: fire = validTri_R10H && halt_RnnnnL.
- Output register load: the register may load when !validTri_R10H || halt_RnnnnL.
  - Source is the FIFO head if the FIFO is non-empty.
  - Otherwise the source is the same-cycle push (bypass).
  - Otherwise validTri_R10H drops to 0.
- Halt: while validTri_R10H=1 and halt_RnnnnL=0, tri_R10S, color_R10U and validTri_R10H hold exactly. While halted the FIFO still accepts pushes until full.
- Latency: push into an empty feeder with halt_RnnnnL=1 gives validTri_R10H=1 on the next cycle. Back-to-back pushes sustain one triangle per cycle with no bubbles.
- Simultaneous push and pop on a full FIFO: no push, because in_ready=0 was computed from the registered count. Push and pop on a non-full FIFO leave fifo_count unchanged.
- Ordering: strict FIFO; no reordering or duplication.
- Counters:
  - occupancy = fifo_count + validTri_R10H.
  - issued_count increments on each fire and wraps 0xFFFF -> 0x0000.
- halt_RnnnnL with validTri_R10H=0 is ignored.
- Reset mid-operation discards all buffered triangles with no partial output.

Optional Feature:
- Macro: RAST_FEED_DEGEN_DROP_EN
- Enabled:
  - On push, compute area2 = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0), full width 2*SIGFIG+2, no truncation.
  - area2==0: the triangle is accepted (in_ready handshake completes) but not written to the FIFO, and a 16-bit dropped_count output increments, wrapping.
  - Degenerate triangles never reach rast and never increment issued_count.
  - Pipelining the check is forbidden; the drop decision is made in the push cycle.
- Disabled: no area logic, no dropped_count port, and all triangles pass.

Test Plan:
- Reset then single push:
  - Stimulus: tri vertices (0,0),(4096,0),(0,4096), color {0xFF,0,0}, halt=1.
  - Response: validTri_R10H=1 next cycle with identical data; issued_count=1 after fire; occupancy 1 -> 0.
- Halt hold:
  - Stimulus: push 6 triangles with halt_RnnnnL=0.
  - Response: triangle 0 is held on outputs unchanged; FIFO fills to 4; in_ready=0 with occupancy=5 and the 6th is stalled.
  - Then release halt: 6 triangles emerge in order on consecutive cycles; issued_count=6.
- Streaming with random halt (~30% low), 200 triangles:
  - Response: scoreboard shows exact order, no loss or duplication; outputs never change while validTri_R10H=1 and halt_RnnnnL=0.
- Bypass/push-pop equality:
  - Stimulus: continuous in_valid, halt=1.
  - Response: one triangle per cycle; occupancy stays at 1.
- Async reset mid-stream:
  - Stimulus: assert rst=0 mid-clock with 3 triangles buffered.
  - Response: validTri_R10H=0 immediately and occupancy=0; after release, the first new push appears alone.
- With RAST_FEED_DEGEN_DROP_EN:
  - Stimulus: push collinear (0,0),(1024,1024),(2048,2048), then a valid triangle.
  - Response: dropped_count=1; only the second triangle reaches rast; issued_count=1.
